score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Game-score bookkeeping stage for meteor_dodge; sits directly upstream of the per-digit seven_seg_decoder instances.
- Counts dodged meteors as a 4-digit packed BCD score, tracks the session high score, and runs the IDLE/PLAYING/OVER game-phase FSM.
- Produces leading-zero blank flags and a game-over blink enable; the top level uses these to gate decoder outputs to all-off (7'b1111111).
- Every nibble it emits is 0-9, so the decoders never see A-F.

Parameters:
- BLINK_CYCLES, 25_000_000, clk cycles per blink half-period in OVER (0.5 s at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; clears score, enters PLAYING
- dodge  input  1  single-cycle pulse; adds 1 to score while PLAYING
- hit  input  1  single-cycle pulse; player struck, ends game
- score_bcd  output  16  current score; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands
- high_bcd  output  16  high score, same packing
- score_blank  output  4  per-digit leading-zero blank for score_bcd; bit i maps to digit i
- playing  output  1  high in PLAYING
- game_over  output  1  high in OVER
- blink  output  1  display enable: toggles in OVER, constant 1 otherwise

Behaviour:
- One clock, clk. reset_n is asynchronous, active-low.
- While reset_n=0, and immediately on its assertion, including mid-game:
  - state=IDLE; score_bcd=0; high_bcd=0; blink=1; blink counter=0
  - playing=0; game_over=0; score_blank=4'b1110
- All outputs are registered or decoded from registers. An input pulse sampled at edge N is visible after edge N.
- FSM, evaluated each rising edge, in priority order:
  - IDLE: start -> PLAYING, score cleared. dodge and hit ignored.
  - PLAYING:
    - start -> stays PLAYING, score cleared, high_bcd unchanged (restart).
    - else hit -> OVER. If score_bcd > high_bcd (unsigned compare on the packed 16 bits), high_bcd <= score_bcd on the same edge. dodge in the same cycle is dropped.
    - else dodge -> score += 1.
  - OVER: start -> PLAYING, score cleared, high_bcd kept. dodge and hit ignored. Score is held for display.
- BCD increment:
  - Ones digit 9 -> 0 with carry into tens; the carry ripples through all four digits in the same cycle.
  - 0009->0010, 0099->0100, 0999->1000.
  - Saturates at 9999: further dodges leave it at 9999; no wrap to 0000.
- score_blank (combinational from score_bcd):
  - bit0 = 0 always.
  - For i = 1..3, bit i = 1 when digits i through 3 are all zero.
  - Examples: 0000 -> 1110; 0042 -> 1100; 1005 -> 0000.
- Blink:
  - On the edge entering OVER: counter = 0, blink = 1.
  - In OVER the counter increments each cycle. When it reaches BLINK_CYCLES-1 it wraps to 0 and blink toggles.
  - First toggle lands BLINK_CYCLES cycles after entry.
  - Leaving OVER forces blink = 1 and counter = 0 on that edge.
- playing and game_over are decodes of state and are never both 1.

Test Plan:
- Reset and idle: assert reset_n=0 mid-PLAYING with score 0037 -> all outputs at reset values within the same cycle, no clock needed; release, pulse dodge x3 in IDLE -> score_bcd stays 0000.
- Carry chain: start, then 9 dodges -> 0009, score_blank 1110; 1 more -> 0010, blank 1100; preload to 0999 via dodges, 1 more -> 1000, blank 0000.
- Saturation: drive 10001 dodges -> score_bcd = 16'h9999 and holds; playing = 1 throughout.
- High score: game 1 scores 0042, then hit -> game_over = 1, high_bcd = 0042. Game 2 scores 0017, hit -> high_bcd stays 0042. Game 3 scores 0100, hit -> 0100.
- Simultaneous events: at score 0005, hit+dodge together -> OVER, score 0005, high 0005. In OVER, start+hit together -> PLAYING, score 0000. In PLAYING, start+hit together -> stays PLAYING, score 0000, high unchanged.
- Blink with BLINK_CYCLES=4: enter OVER -> blink 1 for 4 cycles, 0 for 4, 1 for 4. Pulse start mid-low phase -> blink = 1 on the next edge and stays 1 in PLAYING.

Source files
------------

// File: rtl/score_keeper_if.sv
// ============================================================================
// Module : score_keeper_if
// Brief  : Game-event inputs and score/phase display outputs of score_keeper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface score_keeper_if;
    logic        start;
    logic        dodge;
    logic        hit;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic [3:0]  score_blank;
    logic        playing;
    logic        game_over;
    logic        blink;

    modport master (
        output start, dodge, hit,
        input  score_bcd, high_bcd, score_blank, playing, game_over, blink
    );

    modport slave (
        input  start, dodge, hit,
        output score_bcd, high_bcd, score_blank, playing, game_over, blink
    );
endinterface

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// Module : score_keeper
// Brief  : BCD score / high-score bookkeeping and IDLE/PLAYING/OVER phase FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_keeper #(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    score_keeper_if.slave   bus
);

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [15:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        OVER    = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      score;
    logic [15:0]      high;
    logic             blink;
    logic [CNT_W-1:0] blink_cnt;

    // Ripple +1 across all four digits in one cycle.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            score     <= 16'h0000;
            high      <= 16'h0000;
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= PLAYING;
                        score <= 16'h0000;
                    end
                end
                PLAYING: begin
                    if (bus.start) begin
                        score <= 16'h0000;
                    end else if (bus.hit) begin
                        state     <= OVER;
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                        if (score > high)
                            high <= score;
                    end else if (bus.dodge && (score != SCORE_MAX)) begin
                        score <= bcd_inc(score);
                    end
                end
                OVER: begin
                    if (bus.start) begin
                        state     <= PLAYING;
                        score     <= 16'h0000;
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                    end else if (blink_cnt == CNT_LAST) begin
                        blink_cnt <= '0;
                        blink     <= ~blink;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    blink     <= 1'b1;
                    blink_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.score_bcd      = score;
    assign bus.high_bcd       = high;
    assign bus.blink          = blink;
    assign bus.playing        = (state == PLAYING);
    assign bus.game_over      = (state == OVER);
    // Ones digit is never blanked so a zero score still shows "0".
    assign bus.score_blank[0] = 1'b0;
    assign bus.score_blank[1] = (score[15:4]  == 12'h000);
    assign bus.score_blank[2] = (score[15:8]  == 8'h00);
    assign bus.score_blank[3] = (score[15:12] == 4'h0);

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module : tb_score_keeper
// Brief  : Directed self-checking bench for score_keeper with BLINK_CYCLES=4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    score_keeper_if bus ();

    score_keeper #(.BLINK_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic d, input logic h);
        bus.start = s;
        bus.dodge = d;
        bus.hit   = h;
        tick();
        bus.start = 1'b0;
        bus.dodge = 1'b0;
        bus.hit   = 1'b0;
    endtask

    task automatic dodges(input int n);
        bus.dodge = 1'b1;
        repeat (n) tick();
        bus.dodge = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if (bus.score_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL %s score_bcd: got %h want 0000", tag, bus.score_bcd);
        end
        n_cmp++;
        if (bus.high_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL %s high_bcd: got %h want 0000", tag, bus.high_bcd);
        end
        n_cmp++;
        if (bus.score_blank !== 4'b1110) begin
            n_fail++; $display("FAIL %s score_blank: got %b want 1110", tag, bus.score_blank);
        end
        n_cmp++;
        if ({bus.playing, bus.game_over, bus.blink} !== 3'b001) begin
            n_fail++; $display("FAIL %s playing/game_over/blink: got %b want 001", tag,
                               {bus.playing, bus.game_over, bus.blink});
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.dodge = 1'b0;
        bus.hit   = 1'b0;
        tick();
        check_reset_values("por");
        reset_n = 1'b1;
        tick();
        dodges(3);
        n_cmp++;
        if (bus.score_bcd !== 16'h0000 || bus.playing !== 1'b0) begin
            n_fail++; $display("FAIL idle_dodge: got score %h playing %b want 0000 0",
                               bus.score_bcd, bus.playing);
        end
    endtask

    task automatic test_carry();
        pulse(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.playing !== 1'b1 || bus.score_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL start: got playing %b score %h want 1 0000",
                               bus.playing, bus.score_bcd);
        end
        dodges(9);
        n_cmp++;
        if (bus.score_bcd !== 16'h0009 || bus.score_blank !== 4'b1110) begin
            n_fail++; $display("FAIL carry_0009: got %h/%b want 0009/1110", bus.score_bcd, bus.score_blank);
        end
        dodges(1);
        n_cmp++;
        if (bus.score_bcd !== 16'h0010 || bus.score_blank !== 4'b1100) begin
            n_fail++; $display("FAIL carry_0010: got %h/%b want 0010/1100", bus.score_bcd, bus.score_blank);
        end
        dodges(989);
        n_cmp++;
        if (bus.score_bcd !== 16'h0999 || bus.score_blank !== 4'b1000) begin
            n_fail++; $display("FAIL carry_0999: got %h/%b want 0999/1000", bus.score_bcd, bus.score_blank);
        end
        dodges(1);
        n_cmp++;
        if (bus.score_bcd !== 16'h1000 || bus.score_blank !== 4'b0000) begin
            n_fail++; $display("FAIL carry_1000: got %h/%b want 1000/0000", bus.score_bcd, bus.score_blank);
        end
    endtask

    task automatic test_saturation();
        logic play_ok;
        play_ok = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        bus.dodge = 1'b1;
        for (int i = 0; i < 10001; i++) begin
            tick();
            if (bus.playing !== 1'b1) play_ok = 1'b0;
        end
        bus.dodge = 1'b0;
        n_cmp++;
        if (bus.score_bcd !== 16'h9999) begin
            n_fail++; $display("FAIL saturate: got %h want 9999", bus.score_bcd);
        end
        n_cmp++;
        if (play_ok !== 1'b1) begin
            n_fail++; $display("FAIL saturate_playing: got playing dropout %b want 1", play_ok);
        end
        dodges(5);
        n_cmp++;
        if (bus.score_bcd !== 16'h9999) begin
            n_fail++; $display("FAIL saturate_hold: got %h want 9999", bus.score_bcd);
        end
    endtask

    task automatic test_high_score();
        pulse(1'b1, 1'b0, 1'b0);
        dodges(42);
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({bus.playing, bus.game_over} !== 2'b01 || bus.high_bcd !== 16'h0042 ||
            bus.score_bcd !== 16'h0042) begin
            n_fail++; $display("FAIL game1: got pl/go %b%b high %h score %h want 01 0042 0042",
                               bus.playing, bus.game_over, bus.high_bcd, bus.score_bcd);
        end
        pulse(1'b1, 1'b0, 1'b0);
        dodges(17);
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.high_bcd !== 16'h0042 || bus.score_bcd !== 16'h0017) begin
            n_fail++; $display("FAIL game2: got high %h score %h want 0042 0017", bus.high_bcd, bus.score_bcd);
        end
        pulse(1'b1, 1'b0, 1'b0);
        dodges(100);
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.high_bcd !== 16'h0100) begin
            n_fail++; $display("FAIL game3: got high %h want 0100", bus.high_bcd);
        end
    endtask

    task automatic test_simultaneous();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        dodges(5);
        pulse(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (bus.game_over !== 1'b1 || bus.score_bcd !== 16'h0005 || bus.high_bcd !== 16'h0005) begin
            n_fail++; $display("FAIL hit_dodge: got go %b score %h high %h want 1 0005 0005",
                               bus.game_over, bus.score_bcd, bus.high_bcd);
        end
        pulse(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.playing !== 1'b1 || bus.game_over !== 1'b0 || bus.score_bcd !== 16'h0000) begin
            n_fail++; $display("FAIL over_start_hit: got pl %b go %b score %h want 1 0 0000",
                               bus.playing, bus.game_over, bus.score_bcd);
        end
        dodges(3);
        pulse(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.playing !== 1'b1 || bus.score_bcd !== 16'h0000 || bus.high_bcd !== 16'h0005) begin
            n_fail++; $display("FAIL play_start_hit: got pl %b score %h high %h want 1 0000 0005",
                               bus.playing, bus.score_bcd, bus.high_bcd);
        end
    endtask

    task automatic test_blink();
        logic exp_b;
        dodges(2);
        pulse(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 14; k++) begin
            exp_b = (((k / 4) % 2) == 0);
            n_cmp++;
            if (bus.blink !== exp_b || bus.game_over !== 1'b1) begin
                n_fail++; $display("FAIL blink_k%0d: got blink %b go %b want %b 1",
                                   k, bus.blink, bus.game_over, exp_b);
            end
            if (k != 13) tick();
        end
        n_cmp++;
        if (bus.high_bcd !== 16'h0005 || bus.score_bcd !== 16'h0002) begin
            n_fail++; $display("FAIL blink_scores: got high %h score %h want 0005 0002",
                               bus.high_bcd, bus.score_bcd);
        end
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (bus.blink !== 1'b1 || bus.playing !== 1'b1 || bus.game_over !== 1'b0) begin
                n_fail++; $display("FAIL blink_leave_k%0d: got blink %b pl %b go %b want 1 1 0",
                                   k, bus.blink, bus.playing, bus.game_over);
            end
            tick();
        end
    endtask

    task automatic test_reset_midgame();
        pulse(1'b1, 1'b0, 1'b0);
        dodges(37);
        n_cmp++;
        if (bus.score_bcd !== 16'h0037 || bus.high_bcd !== 16'h0005) begin
            n_fail++; $display("FAIL pre_reset: got score %h high %h want 0037 0005",
                               bus.score_bcd, bus.high_bcd);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick();
        reset_n = 1'b1;
        tick();
        dodges(3);
        n_cmp++;
        if (bus.score_bcd !== 16'h0000 || bus.playing !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got score %h playing %b want 0000 0",
                               bus.score_bcd, bus.playing);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_carry();
        test_saturation();
        test_high_score();
        test_simultaneous();
        test_blink();
        test_reset_midgame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
